// File: rtl/video_pattern_src.sv
// Raster timing and 10-bit RGB test-pattern source feeding the line-buffer stage.
// Outputs are registered, one cycle behind the h/v counters; start/stop are frame-aligned.
module video_pattern_src #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_enable,
    input  logic [1:0] i_pattern_sel,
    output logic       o_vsync,
    output logic       o_hsync,
    output logic       o_de,
    output logic [9:0] o_r_data,
    output logic [9:0] o_g_data,
    output logic [9:0] o_b_data,
    output logic       o_frame_start,
    output logic       o_busy
);

    localparam logic [11:0] HA       = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] VA       = 12'(V_ACTIVE);
    localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;

    state_t      state_q, state_d;
    logic [11:0] h_q, h_d, v_q, v_d;
    logic [9:0]  frame_q, frame_d;
    logic [1:0]  pat_q, pat_d;
    logic [11:0] bar_px_q, bar_px_d;
    logic [2:0]  bar_idx_q, bar_idx_d;

    logic       vsync_q, vsync_d, hsync_q, hsync_d, de_q, de_d;
    logic       fs_q, fs_d, busy_q, busy_d;
    logic [9:0] r_q, r_d, g_q, g_d, b_q, b_d;

    logic       active, h_last, frame_last;
    logic [1:0] pat_eff;
    logic [2:0] bar_rgb;

    assign active     = (state_q != IDLE);
    assign h_last     = (h_q == H_LAST);
    assign frame_last = h_last && (v_q == V_LAST);
    // The selector is sampled live on pixel (0,0) so the whole frame uses one pattern.
    assign pat_eff    = (h_q == 12'd0 && v_q == 12'd0) ? i_pattern_sel : pat_q;
    assign bar_rgb    = {~bar_idx_q[1], ~bar_idx_q[2], ~bar_idx_q[0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (i_enable) state_d = RUN;
            RUN:       if (!i_enable) state_d = STOP_PEND;
            STOP_PEND: if (i_enable) state_d = RUN;
                       else if (frame_last) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        h_d       = 12'd0;
        v_d       = 12'd0;
        frame_d   = frame_q;
        pat_d     = pat_q;
        bar_px_d  = 12'd0;
        bar_idx_d = 3'd0;
        if (active) begin
            pat_d = pat_eff;
            h_d   = h_last ? 12'd0 : h_q + 12'd1;
            v_d   = h_last ? ((v_q == V_LAST) ? 12'd0 : v_q + 12'd1) : v_q;
            if (frame_last) frame_d = frame_q + 10'd1;
            // Bar index tracks h with a width counter instead of a divide.
            if (!h_last) begin
                if (bar_px_q == BAR_LAST) begin
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_px_d  = bar_px_q + 12'd1;
                    bar_idx_d = bar_idx_q;
                end
            end
        end
    end

    always_comb begin
        vsync_d = 1'b0;
        hsync_d = 1'b0;
        de_d    = 1'b0;
        fs_d    = 1'b0;
        busy_d  = 1'b0;
        r_d     = 10'd0;
        g_d     = 10'd0;
        b_d     = 10'd0;
        if (active) begin
            busy_d  = 1'b1;
            de_d    = (h_q < HA) && (v_q < VA);
            hsync_d = (h_q >= HS_BEG) && (h_q < HS_END);
            vsync_d = (v_q >= VS_BEG) && (v_q < VS_END);
            fs_d    = (h_q == 12'd0) && (v_q == 12'd0);
            if (de_d) begin
                case (pat_eff)
                    2'd0: begin
                        r_d = {10{bar_rgb[2]}};
                        g_d = {10{bar_rgb[1]}};
                        b_d = {10{bar_rgb[0]}};
                    end
                    2'd1: begin
                        r_d = h_q[9:0];
                        g_d = h_q[9:0];
                        b_d = h_q[9:0];
                    end
                    2'd2: begin
                        r_d = {10{~(h_q[3] ^ v_q[3])}};
                        g_d = {10{~(h_q[3] ^ v_q[3])}};
                        b_d = {10{~(h_q[3] ^ v_q[3])}};
                    end
                    default: begin
                        r_d = h_q[9:0];
                        g_d = v_q[9:0];
                        b_d = frame_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_q       <= 12'd0;
            v_q       <= 12'd0;
            frame_q   <= 10'd0;
            pat_q     <= 2'd0;
            bar_px_q  <= 12'd0;
            bar_idx_q <= 3'd0;
            vsync_q   <= 1'b0;
            hsync_q   <= 1'b0;
            de_q      <= 1'b0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
            r_q       <= 10'd0;
            g_q       <= 10'd0;
            b_q       <= 10'd0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            frame_q   <= frame_d;
            pat_q     <= pat_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            vsync_q   <= vsync_d;
            hsync_q   <= hsync_d;
            de_q      <= de_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign o_vsync       = vsync_q;
    assign o_hsync       = hsync_q;
    assign o_de          = de_q;
    assign o_frame_start = fs_q;
    assign o_busy        = busy_q;
    assign o_r_data      = r_q;
    assign o_g_data      = g_q;
    assign o_b_data      = b_q;

endmodule

// File: tb/tb_video_pattern_src.sv
// Bench for video_pattern_src on a 24x8 raster: a cycle model pushes expected outputs,
// each scenario task pops and compares them and adds its own targeted checks.
`timescale 1ns/1ps
module tb_video_pattern_src;

    localparam int HA = 16, HFP = 2, HSW = 2, HBP = 4;
    localparam int VA = 4, VFP = 1, VSW = 1, VBP = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam logic [2:0] BAR_TAB [0:7] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                             3'b101, 3'b100, 3'b001, 3'b000};

    logic       clk = 1'b0;
    logic       rstn, en;
    logic [1:0] sel;
    logic       o_vsync, o_hsync, o_de, o_frame_start, o_busy;
    logic [9:0] o_r_data, o_g_data, o_b_data;

    int checks = 0;
    int errors = 0;
    logic [34:0] sbq[$];
    logic [34:0] act_v, exp_v;

    int m_st, m_h, m_v, m_fc;
    logic [1:0] m_pat;

    video_pattern_src #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .clk(clk), .rstn(rstn), .i_enable(en), .i_pattern_sel(sel),
        .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
        .o_r_data(o_r_data), .o_g_data(o_g_data), .o_b_data(o_b_data),
        .o_frame_start(o_frame_start), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] model_out(int st, int h, int v, int fc, logic [1:0] pat);
        logic de, hs, vs, chk;
        logic [2:0] c;
        logic [9:0] r, g, b;
        if (st == 0) return '0;
        de = (h < HA) && (v < VA);
        hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
        r = 10'd0; g = 10'd0; b = 10'd0;
        if (de) begin
            case (pat)
                2'd0: begin
                    c = BAR_TAB[h / (HA / 8)];
                    r = c[2] ? 10'h3FF : 10'h000;
                    g = c[1] ? 10'h3FF : 10'h000;
                    b = c[0] ? 10'h3FF : 10'h000;
                end
                2'd1: begin r = 10'(h % 1024); g = r; b = r; end
                2'd2: begin
                    chk = (((h / 8) % 2) == ((v / 8) % 2));
                    r = chk ? 10'h3FF : 10'h000; g = r; b = r;
                end
                default: begin r = 10'(h % 1024); g = 10'(v % 1024); b = 10'(fc % 1024); end
            endcase
        end
        return {vs, hs, de, r, g, b, (h == 0 && v == 0), 1'b1};
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_st <= 0; m_h <= 0; m_v <= 0; m_fc <= 0; m_pat <= 2'd0;
            sbq.delete();
        end else begin
            sbq.push_back(model_out(m_st, m_h, m_v, m_fc, (m_h == 0 && m_v == 0) ? sel : m_pat));
            if (m_st != 0) begin
                if (m_h == 0 && m_v == 0) m_pat <= sel;
                if (m_h == HT - 1) begin
                    m_h <= 0;
                    if (m_v == VT - 1) begin
                        m_v  <= 0;
                        m_fc <= (m_fc + 1) % 1024;
                    end else begin
                        m_v <= m_v + 1;
                    end
                end else begin
                    m_h <= m_h + 1;
                end
            end
            case (m_st)
                0: if (en) m_st <= 1;
                1: if (!en) m_st <= 2;
                2: if (en) m_st <= 1;
                   else if (m_h == HT - 1 && m_v == VT - 1) m_st <= 0;
                default: m_st <= 0;
            endcase
        end
    end

    // Advances one cycle and fetches observed/expected vectors; comparisons live in the tasks.
    task automatic cyc();
        @(negedge clk);
        act_v = {o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data, o_frame_start, o_busy};
        exp_v = (sbq.size() > 0) ? sbq.pop_front() : 'x;
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data, o_frame_start, o_busy} !== 35'd0) begin
                errors++;
                $display("FAIL reset_outputs i=%0d got=%h want=0", i,
                         {o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data, o_frame_start, o_busy});
            end
        end
        rstn = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            cyc();
            checks++;
            if (act_v !== exp_v || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle n=%0d got=%h want=%h", n, act_v, exp_v);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_timing();
        int off, hh, vv, fr;
        sel = 2'd3; en = 1'b1;
        for (int n = 1; n <= 800; n++) begin
            cyc();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL sb_timing n=%0d got=%h want=%h", n, act_v, exp_v);
            end
            if (n >= 2 && n <= 2 + 3 * FT - 1) begin
                off = n - 2; hh = off % HT; vv = (off / HT) % VT; fr = off / FT;
                checks++;
                if ({o_de, o_hsync, o_vsync, o_frame_start} !==
                    {(hh < 16 && vv < 4), (hh >= 18 && hh < 20), (vv == 5), (off % FT == 0)}) begin
                    errors++;
                    $display("FAIL raster n=%0d got=%b want=%b", n,
                             {o_de, o_hsync, o_vsync, o_frame_start},
                             {(hh < 16 && vv < 4), (hh >= 18 && hh < 20), (vv == 5), (off % FT == 0)});
                end
                if (hh == 5 && vv == 2) begin
                    checks++;
                    if ({o_r_data, o_g_data, o_b_data} !== {10'd5, 10'd2, 10'(fr)}) begin
                        errors++;
                        $display("FAIL coord_5_2 frame=%0d got=%0d/%0d/%0d want=5/2/%0d",
                                 fr, o_r_data, o_g_data, o_b_data, fr);
                    end
                end
            end
            if (n == 600) en = 1'b0;
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL timing_drain got busy=%b want=0", o_busy);
        end
        $display("test_timing done");
    endtask

    task automatic test_stop();
        sel = 2'd1; en = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            cyc();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL sb_stop n=%0d got=%h want=%h", n, act_v, exp_v);
            end
            checks++;
            if (o_busy !== (n >= 2 && n <= 193)) begin
                errors++;
                $display("FAIL stop_busy n=%0d got=%b want=%b", n, o_busy, (n >= 2 && n <= 193));
            end
            if (n >= 3) begin
                checks++;
                if (o_frame_start !== 1'b0) begin
                    errors++;
                    $display("FAIL stop_no_frame n=%0d got=%b want=0", n, o_frame_start);
                end
            end
            if (n >= 194) begin
                checks++;
                if (act_v !== 35'd0) begin
                    errors++;
                    $display("FAIL stop_quiet n=%0d got=%h want=0", n, act_v);
                end
            end
            if (n == 2 + HT + 3) en = 1'b0;
        end
        $display("test_stop done");
    endtask

    task automatic test_patterns();
        logic [2:0] t;
        sel = 2'd0; en = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            cyc();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL sb_patterns n=%0d got=%h want=%h", n, act_v, exp_v);
            end
            if (n >= 2 && n <= 17) begin
                t = BAR_TAB[(n - 2) / 2];
                checks++;
                if ({o_r_data, o_g_data, o_b_data} !== {{10{t[2]}}, {10{t[1]}}, {10{t[0]}}}) begin
                    errors++;
                    $display("FAIL bars px=%0d got=%h/%h/%h want=%b", n - 2, o_r_data, o_g_data, o_b_data, t);
                end
            end
            if (n >= 18 && n <= 25) begin
                checks++;
                if ({o_de, o_r_data, o_g_data, o_b_data} !== 31'd0) begin
                    errors++;
                    $display("FAIL bars_blank n=%0d got=%h want=0", n, {o_de, o_r_data, o_g_data, o_b_data});
                end
            end
            if (n == 194 || n == 194 + HT) begin
                checks++;
                if ({o_de, o_r_data, o_g_data, o_b_data} !== {1'b1, 30'h3FFFFFFF}) begin
                    errors++;
                    $display("FAIL checker_white n=%0d got=%h want=white", n, {o_de, o_r_data, o_g_data, o_b_data});
                end
            end
            if (n == 194 + 8 || n == 194 + 3 * HT + 15) begin
                checks++;
                if ({o_de, o_r_data, o_g_data, o_b_data} !== {1'b1, 30'd0}) begin
                    errors++;
                    $display("FAIL checker_black n=%0d got=%h want=black", n, {o_de, o_r_data, o_g_data, o_b_data});
                end
            end
            if (n == 100) sel = 2'd2;
            if (n == 250) en = 1'b0;
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL patterns_drain got busy=%b want=0", o_busy);
        end
        $display("test_patterns done");
    endtask

    task automatic test_back_to_back();
        sel = 2'd3; en = 1'b1;
        for (int n = 1; n <= 600; n++) begin
            cyc();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL sb_b2b n=%0d got=%h want=%h", n, act_v, exp_v);
            end
            if (n >= 2 && n <= 400) begin
                checks++;
                if ({o_busy, o_frame_start} !== {1'b1, ((n - 2) % FT == 0)}) begin
                    errors++;
                    $display("FAIL b2b_continuous n=%0d got=%b want=%b", n,
                             {o_busy, o_frame_start}, {1'b1, ((n - 2) % FT == 0)});
                end
            end
            if (n == 30) en = 1'b0;
            if (n == 80) en = 1'b1;
            if (n == 400) en = 1'b0;
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got busy=%b want=0", o_busy);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        sel = 2'd3; en = 1'b1;
        for (int n = 1; n <= 55; n++) begin
            cyc();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL sb_pre_reset n=%0d got=%h want=%h", n, act_v, exp_v);
            end
        end
        #2 rstn = 1'b0; en = 1'b0;
        #1;
        checks++;
        if ({o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data, o_frame_start, o_busy} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset got=%h want=0",
                     {o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data, o_frame_start, o_busy});
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            checks++;
            if (act_v !== exp_v || {o_busy, o_de} !== 2'b00) begin
                errors++;
                $display("FAIL post_reset_idle n=%0d got=%h want=%h", n, act_v, exp_v);
            end
        end
        en = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            cyc();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL sb_restart n=%0d got=%h want=%h", n, act_v, exp_v);
            end
            if (n == 2) begin
                checks++;
                if ({o_frame_start, o_de} !== 2'b11) begin
                    errors++;
                    $display("FAIL restart_first_pixel got=%b want=11", {o_frame_start, o_de});
                end
            end
            if (n == 10) en = 1'b0;
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_timing();
        test_stop();
        test_patterns();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
